// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - op_e    : operation encodings (MUL, MULH, DIV, REM)
//   - state_e : control FSM states (IDLE, RUN, FIX, DONE)
//   - clog2() : counter-width helper used to size the step counter
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,  // low WIDTH bits of the product
        OP_MULH = 2'b01,  // high WIDTH bits of the product
        OP_DIV  = 2'b10,  // quotient, truncated toward zero
        OP_REM  = 2'b11   // remainder, sign follows the dividend
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // Smallest n with 2**n >= value (minimum 1 so counters never collapse).
    function automatic int clog2(input int value);
        int n;
        n = 1;
        while ((1 << n) < value) begin
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/muldiv_absneg.sv
// -----------------------------------------------------------------------------
// muldiv_absneg
// Combinational conditional two's-complement negate. Used both to take the
// magnitude of a signed operand (i_negate = sign bit) and to re-apply the
// result sign during fix-up.
//
// Ports:
//   i_value  [WIDTH-1:0]  value to condition
//   i_negate              1 = output -i_value, 0 = pass through
//   o_value  [WIDTH-1:0]  conditioned value
// -----------------------------------------------------------------------------
module muldiv_absneg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);

    // Magnitude of the most negative value is itself, which read as unsigned
    // is exactly 2**(WIDTH-1): the datapath relies on that.
    assign o_value = i_negate ? ((~i_value) + WIDTH'(1)) : i_value;

endmodule

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Parametrised iterative multiply/divide unit for the execute stage.
// Radix-2: one shift-add (multiply) or restoring shift-subtract (divide) step
// per clock, on operand magnitudes; the sign is re-applied in FIX.
// FSM: IDLE -> RUN (WIDTH cycles) -> FIX -> DONE -> IDLE.
//
// Parameters:
//   WIDTH  operand/result width, >= 4 and even (default 32)
//
// Ports:
//   i_clock      rising-edge clock
//   i_reset      asynchronous active-low reset
//   i_start      request, accepted in IDLE or DONE
//   i_op         00 MUL, 01 MULH, 10 DIV, 11 REM
//   i_is_signed  1 = two's-complement operands
//   i_kill       synchronous abort (priority over i_start)
//   i_operand_a  multiplicand / dividend
//   i_operand_b  multiplier / divisor
//   o_result     result, held until FIX of the next accepted operation
//   o_exception  overflow / divide-by-zero flag, held with o_result
//   o_busy       high in RUN and FIX
//   o_ready      one-cycle pulse in DONE
//
// Build option:
//   MULDIV_ZERO_SHORTCUT_EN  when defined, a zero MUL/MULH operand or a zero
//                            divisor skips RUN and goes straight to FIX.
// -----------------------------------------------------------------------------
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic             i_is_signed,
    input  logic             i_kill,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_exception,
    output logic             o_busy,
    output logic             o_ready
);

    localparam int                 CNT_W   = clog2(WIDTH);
    localparam logic [CNT_W-1:0]   LAST    = CNT_W'(WIDTH - 1);
    // Largest positive / most negative signed products, as magnitudes.
    localparam logic [2*WIDTH-1:0] POS_LIM = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [2*WIDTH-1:0] NEG_LIM = POS_LIM + (2*WIDTH)'(1);

    state_e               r_state;
    state_e               w_next_state;
    op_e                  r_op;
    logic                 r_signed;
    logic                 r_neg;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_operand;   // multiplicand (MUL*) or divisor (DIV/REM)
    logic [2*WIDTH-1:0]   r_acc;       // {hi, lo}: product or {remainder, quotient}
    logic [WIDTH-1:0]     r_result;
    logic                 r_exception;

    logic                 w_accept;
    logic                 w_in_is_mul;
    logic                 w_zero_op;
    logic                 w_neg_in;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
    muldiv_absneg #(.WIDTH(WIDTH)) u_abs_a (
        .i_value  (i_operand_a),
        .i_negate (i_is_signed & i_operand_a[WIDTH-1]),
        .o_value  (w_a_mag)
    );

    muldiv_absneg #(.WIDTH(WIDTH)) u_abs_b (
        .i_value  (i_operand_b),
        .i_negate (i_is_signed & i_operand_b[WIDTH-1]),
        .o_value  (w_b_mag)
    );

    assign w_accept    = i_start && !i_kill && (r_state == S_IDLE || r_state == S_DONE);
    assign w_in_is_mul = !i_op[1];
    assign w_zero_op   = w_in_is_mul ? (i_operand_a == '0 || i_operand_b == '0)
                                     : (i_operand_b == '0);
    // Remainder takes the dividend's sign; everything else the XOR of signs.
    assign w_neg_in    = i_is_signed &&
                         ((op_e'(i_op) == OP_REM) ? i_operand_a[WIDTH-1]
                                                  : (i_operand_a[WIDTH-1] ^ i_operand_b[WIDTH-1]));

    // ------------------------------------------------------------------
    // Radix-2 step logic
    // ------------------------------------------------------------------
    logic                 w_is_mul;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_top;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_diff;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_is_mul   = (r_op == OP_MUL) || (r_op == OP_MULH);

    // Shift-add: add the multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole register right, carry included.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_operand} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: the partial remainder shifted left with the next
    // dividend bit can need WIDTH+1 bits, hence the wide compare.
    assign w_div_top  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_ge   = w_div_top >= {1'b0, r_operand};
    assign w_div_diff = w_div_top[WIDTH-1:0] - r_operand;
    assign w_div_next = w_div_ge ? {w_div_diff,           r_acc[WIDTH-2:0], 1'b1}
                                 : {w_div_top[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    // ------------------------------------------------------------------
    // Fix-up: re-apply sign and classify exceptions
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]   w_fix_in;
    logic [2*WIDTH-1:0]   w_fix_out;
    logic [WIDTH-1:0]     w_fix_result;
    logic                 w_div_zero;
    logic                 w_fix_exception;

    // The product is negated as a whole so MULH sees the borrow from the low
    // half; divide results are negated as zero-extended WIDTH-bit values.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_fix_in = r_acc;
        if (r_op == OP_DIV) begin
            w_fix_in = {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]};
        end else if (r_op == OP_REM) begin
            w_fix_in = {{WIDTH{1'b0}}, r_acc[2*WIDTH-1:WIDTH]};
        end
    end

    muldiv_absneg #(.WIDTH(2*WIDTH)) u_fix (
        .i_value  (w_fix_in),
        .i_negate (r_neg),
        .o_value  (w_fix_out)
    );

    assign w_div_zero = !w_is_mul && (r_operand == '0);

    always_comb begin
        w_fix_result    = (r_op == OP_MULH) ? w_fix_out[2*WIDTH-1:WIDTH] : w_fix_out[WIDTH-1:0];
        w_fix_exception = 1'b0;
        unique case (r_op)
            OP_MUL:  w_fix_exception = r_signed ? (r_neg ? (r_acc > NEG_LIM) : (r_acc > POS_LIM))
                                                : (r_acc[2*WIDTH-1:WIDTH] != '0);
            OP_MULH: w_fix_exception = 1'b0;
            // A positive quotient with the top bit set only arises from MIN / -1.
            OP_DIV:  w_fix_exception = w_div_zero || (r_signed && !r_neg && r_acc[WIDTH-1]);
            OP_REM:  w_fix_exception = w_div_zero;
            default: w_fix_exception = 1'b0;
        endcase
        if (w_div_zero) begin
            w_fix_result = '0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_kill) begin
            w_next_state = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    w_next_state = S_IDLE;
                    if (i_start) begin
`ifdef MULDIV_ZERO_SHORTCUT_EN
                        w_next_state = w_zero_op ? S_FIX : S_RUN;
`else
                        w_next_state = S_RUN;
`endif
                    end
                end
                S_RUN:   w_next_state = (r_cnt == LAST) ? S_FIX : S_RUN;
                S_FIX:   w_next_state = S_DONE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy  = (r_state == S_RUN) || (r_state == S_FIX);
        o_ready = (r_state == S_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: datapath registers are reset too; the result must read 0 out of reset and the cost is small.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_op        <= OP_MUL;
            r_signed    <= 1'b0;
            r_neg       <= 1'b0;
            r_cnt       <= '0;
            r_operand   <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op      <= op_e'(i_op);
                r_signed  <= i_is_signed;
                r_neg     <= w_neg_in;
                r_cnt     <= '0;
                r_operand <= w_in_is_mul ? w_a_mag : w_b_mag;
                // A zero operand loads a zero product so the shortcut path
                // lands in FIX with the right value already in place.
                if (w_in_is_mul) begin
                    r_acc <= w_zero_op ? '0 : {{WIDTH{1'b0}}, w_b_mag};
                end else begin
                    r_acc <= {{WIDTH{1'b0}}, w_a_mag};
                end
            end else if (r_state == S_RUN) begin
                r_acc <= w_is_mul ? w_mul_next : w_div_next;
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_state == S_FIX && !i_kill) begin
                r_result    <= w_fix_result;
                r_exception <= w_fix_exception;
            end
        end
    end

    assign o_result    = r_result;
    assign o_exception = r_exception;

endmodule

// File: tb/tb_muldiv_iter.sv
// -----------------------------------------------------------------------------
// tb_muldiv_iter
// Directed, table-driven bench for muldiv_iter (WIDTH=32), plus hand-written
// sequences for back-to-back issue, kill, kill-in-DONE and asynchronous reset.
// Latency is the edge, counted from the start edge, at which ready is
// sampled high: WIDTH+2 normally, 2 on the zero shortcut.
// -----------------------------------------------------------------------------
module tb_muldiv_iter;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;
`ifdef MULDIV_ZERO_SHORTCUT_EN
    localparam bit SHORTCUT = 1'b1;
`else
    localparam bit SHORTCUT = 1'b0;
`endif
    localparam int LAT_FULL = WIDTH + 2;
    localparam int BUDGET   = 200;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic             is_signed;
    logic             kill;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] result;
    logic             exception;
    logic             busy;
    logic             ready;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_iter #(.WIDTH(WIDTH)) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_start     (start),
        .i_op        (op),
        .i_is_signed (is_signed),
        .i_kill      (kill),
        .i_operand_a (operand_a),
        .i_operand_b (operand_b),
        .o_result    (result),
        .o_exception (exception),
        .o_busy      (busy),
        .o_ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        op_e         op;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          exc;
        bit          zero;   // qualifies for the zero shortcut
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns the number of edges after the current point until ready is seen.
    task automatic wait_ready(output int edges, output bit ok);
        edges = 0;
        ok    = 1'b0;
        while (edges < BUDGET) begin
            @(posedge clk);
            #1;
            edges++;
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_op(input op_e o, input bit s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op        = o;
        is_signed = s;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int  edges;
        bit  ok;
        int  exp_lat;
        int  ready_seen;

        vecs[0]  = '{OP_MUL,  1'b1, 32'hFFFF_FFFA, 32'h0000_0007, 32'hFFFF_FFD6, 1'b0, 1'b0};
        vecs[1]  = '{OP_MULH, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2]  = '{OP_MUL,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0};
        vecs[3]  = '{OP_DIV,  1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 1'b0};
        vecs[4]  = '{OP_REM,  1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[5]  = '{OP_DIV,  1'b0, 32'd100,       32'd0,         32'h0000_0000, 1'b1, 1'b1};
        vecs[6]  = '{OP_MULH, 1'b1, 32'hFFFF_FFFA, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[7]  = '{OP_MUL,  1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[8]  = '{OP_MUL,  1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0};
        vecs[9]  = '{OP_MUL,  1'b1, 32'h4000_0000, 32'h0000_0002, 32'h8000_0000, 1'b1, 1'b0};
        vecs[10] = '{OP_DIV,  1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 1'b0, 1'b0};
        vecs[11] = '{OP_REM,  1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 1'b0, 1'b0};
        vecs[12] = '{OP_REM,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
        vecs[13] = '{OP_DIV,  1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0};
        vecs[14] = '{OP_REM,  1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[15] = '{OP_MUL,  1'b0, 32'h0000_0000, 32'd12345,     32'h0000_0000, 1'b0, 1'b1};
        vecs[16] = '{OP_MULH, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0};

        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'b00;
        is_signed = 1'b0;
        kill      = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset result", result, 0);
        check("reset exception", exception, 0);
        check("reset busy", busy, 0);
        check("reset ready", ready, 0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NV; i++) begin
            start_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b);
            exp_lat = (SHORTCUT && vecs[i].zero) ? 2 : LAT_FULL;
            wait_ready(edges, ok);
            check($sformatf("vec%0d ready seen", i), ok, 1);
            check($sformatf("vec%0d result", i), result, vecs[i].res);
            check($sformatf("vec%0d exception", i), exception, vecs[i].exc);
            check($sformatf("vec%0d latency", i), edges + 1, exp_lat);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d ready pulse width", i), ready, 0);
        end

        // ---------------- back-to-back with stray start while busy ----------------
        start_op(OP_MUL, 1'b0, 32'd3, 32'd4);
        wait_ready(edges, ok);
        check("b2b first ready", ok, 1);
        check("b2b first result", result, 12);
        op        = OP_DIV;
        is_signed = 1'b1;
        operand_a = 32'h8000_0000;
        operand_b = 32'hFFFF_FFFF;
        start     = 1'b1;
        @(posedge clk);
        #1;
        check("b2b accepted in DONE", busy, 1);
        check("b2b result held", result, 12);
        // Request while busy: must be ignored.
        op        = OP_MUL;
        operand_a = 32'd1;
        operand_b = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_ready(edges, ok);
        check("b2b second ready", ok, 1);
        check("b2b second result", result, 32'h8000_0000);
        check("b2b second exception", exception, 1);
        check("b2b second latency", edges + 2, LAT_FULL);
        @(posedge clk);
        #1;

        // ---------------- kill mid-RUN ----------------
        start_op(OP_MUL, 1'b0, 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        #1;
        check("kill busy before", busy, 1);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill busy after", busy, 0);
        ready_seen = 0;
        for (int c = 0; c < 2 * LAT_FULL; c++) begin
            @(posedge clk);
            #1;
            if (ready) ready_seen++;
        end
        check("kill no ready", ready_seen, 0);
        check("kill result kept", result, 32'h8000_0000);
        check("kill exception kept", exception, 1);

        // ---------------- kill in DONE (with start) ----------------
        start_op(OP_MUL, 1'b0, 32'd9, 32'd9);
        wait_ready(edges, ok);
        kill  = 1'b1;
        start = 1'b1;
        #1;
        check("done-kill ready still high", ready, 1);
        check("done-kill result", result, 81);
        @(posedge clk);
        #1;
        kill  = 1'b0;
        start = 1'b0;
        check("done-kill start rejected", busy, 0);
        check("done-kill ready gone", ready, 0);

        // ---------------- asynchronous reset mid-RUN ----------------
        start_op(OP_MUL, 1'b0, 32'd7, 32'd7);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async busy", busy, 0);
        check("async result", result, 0);
        check("async ready", ready, 0);
        check("async exception", exception, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(OP_MUL, 1'b0, 32'd5, 32'd5);
        wait_ready(edges, ok);
        check("post-reset ready", ok, 1);
        check("post-reset result", result, 25);
        check("post-reset latency", edges + 1, LAT_FULL);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
